led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL take parameter CLK_HZ, default 50000000, giving the clk frequency in Hz.
REQ-002 The block SHALL take parameter TICK_HZ, default 10, giving the pattern step rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ.
REQ-003 The block SHALL take parameter DEB_MS, default 10, giving the debounce time; DEB_CYC = (CLK_HZ/1000)*DEB_MS.
REQ-004 The block SHALL take parameter BRIGHT, default 8, giving the PWM duty in sixteenths; it is used only with LED_PWM_EN.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing pushbutton, active-high.
REQ-008 The block SHALL have port en, input, 1 bit: run enable, active-high.
REQ-009 The block SHALL have port led, output, 1 bit: registered LED drive to the top-level led pin.
REQ-010 The block SHALL have port mode, output, 2 bits: current pattern mode.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle step strobe.

Function
REQ-012 btn SHALL pass through a two-flop synchronizer before any other use.
REQ-013 The debounced level SHALL take the synchronized value only after that value has differed from the current debounced level for DEB_CYC consecutive cycles.
REQ-014 Any cycle of agreement SHALL clear the debounce counter.
REQ-015 A debounced 0->1 transition SHALL advance mode on the next cycle: OFF(0) -> ON(1) -> BLINK(2) -> HEARTBEAT(3) -> OFF(0), wrapping.
REQ-016 A debounced 1->0 transition SHALL have no effect.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 while en=1, then wrap to 0.
REQ-018 tick SHALL be 1 for exactly the cycle in which the prescaler equals TICK_DIV-1.
REQ-019 A 3-bit step counter SHALL increment on each tick and wrap from 7 to 0.
REQ-020 The pattern bit SHALL be defined per mode:
- OFF = 0
- ON = 1
- BLINK = ~step[2] (4 steps on, 4 steps off)
- HEARTBEAT = 1 only at step 0 and step 2.
REQ-021 led SHALL register the pattern bit, giving one cycle of latency from step/mode to led.
REQ-022 On a mode change, the prescaler and step counter SHALL both load 0 in the same cycle that mode updates.
REQ-023 When en=0:
- prescaler and step SHALL hold their values
- tick SHALL be 0
- led SHALL be 0 from the next cycle
- button and mode handling SHALL continue.
REQ-024 When en returns to 1, counting SHALL resume from the held prescaler and step values.

Reset
REQ-025 When rst=0 at a clk edge, all of the following SHALL take 0 at that edge: synchronizer flops, debounce counter, debounced level, mode, prescaler, step, tick, led, and the PWM counter.
REQ-026 Reset asserted mid-pattern or mid-debounce SHALL discard all progress, with no residual mode advance after release.

Configuration
REQ-027 With macro LED_PWM_EN defined:
- a free-running 4-bit PWM counter SHALL be present
- led SHALL be the registered value of (pattern bit AND pwm_cnt < BRIGHT)
- BRIGHT=16 SHALL give full on; BRIGHT=0 SHALL give always off.
REQ-028 Without LED_PWM_EN, there SHALL be no PWM counter and led SHALL equal the registered pattern bit.

Structure
REQ-029 Mode encodings (MODE_OFF, MODE_ON, MODE_BLINK, MODE_HEART) and the heartbeat step constants SHALL live in shared package led_pkg.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, which outputs the debounced level and a one-cycle rising-edge pulse.

Verification
All scenarios use CLK_HZ=1000, TICK_HZ=100, DEB_MS=2, giving TICK_DIV=10 and DEB_CYC=2.
REQ-031 Reset: hold rst=0 for 3 cycles with btn=1 -> led=0, mode=0, tick=0 throughout; no mode advance until btn is held for the full debounce after release.
REQ-032 Bounce: btn high for 1 cycle, then low -> mode stays 0; btn held high for 6 cycles -> mode=1 within 5 cycles of the rising edge, and led=1 one cycle after mode=1.
REQ-033 Blink: mode=2, en=1 -> tick every 10 cycles; led high for 40 cycles, then low for 40 cycles, repeating.
REQ-034 Heartbeat and wrap: mode=3 -> per-step led sequence 1,0,1,0,0,0,0,0; one further press -> mode=0, led=0, prescaler and step both 0.
REQ-035 Enable hold: en=0 at step 3 of BLINK for 25 cycles -> tick=0, led=0, step stays 3; on en=1, the next tick arrives after the remaining prescaler count.
REQ-036 With LED_PWM_EN, BRIGHT=8, mode=1 -> led alternates 8 cycles high and 8 cycles low; with BRIGHT=0 -> led stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings,
// heartbeat step positions and the per-mode pattern lookup.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HEART = 2'd3
  } mode_e;

  // Steps (out of 8) at which the heartbeat pattern lights the LED.
  localparam logic [2:0] HEART_STEP_A = 3'd0;
  localparam logic [2:0] HEART_STEP_B = 3'd2;

  function automatic logic pattern_bit(input mode_e mode, input logic [2:0] step);
    case (mode)
      MODE_ON:    return 1'b1;
      MODE_BLINK: return ~step[2];
      MODE_HEART: return (step == HEART_STEP_A) || (step == HEART_STEP_B);
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for a bouncing pushbutton;
// emits the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // The count only survives while the synchronized input disagrees with the level.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Button-selectable LED pattern generator (off / on / blink / heartbeat).
// Define LED_PWM_EN to dim the LED with a free-running 4-bit PWM at BRIGHT/16 duty.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10,
  parameter int DEB_MS  = 10,
  parameter int BRIGHT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       en,
  output logic       led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DEB_CYC  = (CLK_HZ / 1000) * DEB_MS;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic btn_level_unused;
  logic btn_rise;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .level (btn_level_unused),
    .rise  (btn_rise)
  );

  mode_e              mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         step_q, step_d;
  logic               led_q, led_d;
  logic               pwm_on;

`ifdef LED_PWM_EN
  logic [3:0] pwm_q, pwm_d;

  assign pwm_d  = pwm_q + 4'd1;
  assign pwm_on = {1'b0, pwm_q} < 5'(BRIGHT);

  always_ff @(posedge clk) begin
    if (!rst) pwm_q <= '0;
    else      pwm_q <= pwm_d;
  end
`else
  logic [4:0] bright_unused;

  assign bright_unused = 5'(BRIGHT);
  assign pwm_on        = 1'b1;
`endif

  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q;
    step_d  = step_q;
    tick    = en && (presc_q == PRESC_LAST);
    // A mode change restarts the pattern from its first step.
    if (btn_rise) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      presc_d = '0;
      step_d  = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) step_d = step_q + 3'd1;
    end
    led_d = en & pattern_bit(mode_q, step_q) & pwm_on;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= MODE_OFF;
      presc_q <= '0;
      step_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen at CLK_HZ=1000, TICK_HZ=100, DEB_MS=2
// (TICK_DIV=10, DEB_CYC=2); PWM scenarios run only when LED_PWM_EN is defined.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       en  = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DEB_MS  (2),
    .BRIGHT  (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .en   (en),
    .led  (led),
    .mode (mode),
    .tick (tick)
  );

`ifdef LED_PWM_EN
  logic       led0;
  logic [1:0] mode0;
  logic       tick0;

  led_pattern_gen #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DEB_MS  (2),
    .BRIGHT  (0)
  ) dut0 (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .en   (en),
    .led  (led0),
    .mode (mode0),
    .tick (tick0)
  );
`endif

  typedef struct {
    logic       led;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_mis     = 0;
  int   since_rst = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic clock();
    @(posedge clk);
    since_rst = rst ? since_rst + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn = 1'b0;
    en  = 1'b1;
    clock();
    clock();
    rst = 1'b1;
  endtask

  // Returns just after the edge at which mode advances.
  task automatic press();
    btn = 1'b0;
    repeat (4) clock();
    btn = 1'b1;
    repeat (5) clock();
    btn = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [1:0] mode_seq [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    rst = 1'b0;
    btn = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{led: 1'b0, mode: 2'd0, tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || mode !== e.mode || tick !== e.tick) begin
        n_mis++;
        $display("FAIL reset_hold cyc=%0d got led=%b mode=%0d tick=%b want led=%b mode=%0d tick=%b",
                 i, led, mode, tick, e.led, e.mode, e.tick);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{led: 1'b0, mode: mode_seq[i], tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (mode !== e.mode) begin
        n_mis++;
        $display("FAIL reset_release cyc=%0d got mode=%0d want mode=%0d", i, mode, e.mode);
      end
    end
    // Reset in the middle of a debounce must leave no pending advance.
    do_reset();
    btn = 1'b1;
    repeat (3) clock();
    rst = 1'b0;
    btn = 1'b0;
    clock();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{led: 1'b0, mode: 2'd0, tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (mode !== e.mode || led !== e.led) begin
        n_mis++;
        $display("FAIL reset_mid cyc=%0d got mode=%0d led=%b want mode=%0d led=%b",
                 i, mode, led, e.mode, e.led);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [1:0] mode_seq [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic       led_seq  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    btn = 1'b1;
    clock();
    btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{led: 1'b0, mode: 2'd0, tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (mode !== e.mode || led !== e.led) begin
        n_mis++;
        $display("FAIL bounce_glitch cyc=%0d got mode=%0d led=%b want mode=%0d led=%b",
                 i, mode, led, e.mode, e.led);
      end
    end
    btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{led: led_seq[i], mode: mode_seq[i], tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (mode !== e.mode || led !== e.led) begin
        n_mis++;
        $display("FAIL bounce_hold cyc=%0d got mode=%0d led=%b want mode=%0d led=%b",
                 i, mode, led, e.mode, e.led);
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_blink();
    exp_t e;
    int   s;
    do_reset();
    press();
    press();
    n_cmp++;
    if (mode !== 2'd2) begin
      n_mis++;
      $display("FAIL blink_mode got mode=%0d want mode=2", mode);
    end
    for (int k = 1; k <= 90; k++) begin
      s = ((k - 1) / 10) % 8;
      sb.push_back('{led: (s < 4), mode: 2'd2, tick: (k % 10 == 9)});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick || mode !== e.mode) begin
        n_mis++;
        $display("FAIL blink k=%0d got led=%b tick=%b mode=%0d want led=%b tick=%b mode=%0d",
                 k, led, tick, mode, e.led, e.tick, e.mode);
      end
    end
  endtask

  task automatic test_heartbeat();
    exp_t e;
    int   s;
    press();
    n_cmp++;
    if (mode !== 2'd3) begin
      n_mis++;
      $display("FAIL heart_mode got mode=%0d want mode=3", mode);
    end
    for (int k = 1; k <= 80; k++) begin
      s = (k - 1) / 10;
      sb.push_back('{led: (s == 0 || s == 2), mode: 2'd3, tick: (k % 10 == 9)});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick) begin
        n_mis++;
        $display("FAIL heart k=%0d got led=%b tick=%b want led=%b tick=%b",
                 k, led, tick, e.led, e.tick);
      end
    end
    press();
    n_cmp++;
    if (mode !== 2'd0 || dut.presc_q !== '0 || dut.step_q !== 3'd0) begin
      n_mis++;
      $display("FAIL wrap_state got mode=%0d presc=%0d step=%0d want mode=0 presc=0 step=0",
               mode, dut.presc_q, dut.step_q);
    end
    for (int k = 1; k <= 10; k++) begin
      sb.push_back('{led: 1'b0, mode: 2'd0, tick: (k == 9)});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick || mode !== e.mode) begin
        n_mis++;
        $display("FAIL wrap k=%0d got led=%b tick=%b mode=%0d want led=%b tick=%b mode=%0d",
                 k, led, tick, mode, e.led, e.tick, e.mode);
      end
    end
  endtask

  task automatic test_enable_hold();
    exp_t e;
    do_reset();
    press();
    press();
    repeat (35) clock();
    n_cmp++;
    if (dut.step_q !== 3'd3 || led !== 1'b1) begin
      n_mis++;
      $display("FAIL hold_entry got step=%0d led=%b want step=3 led=1", dut.step_q, led);
    end
    en = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      sb.push_back('{led: 1'b0, mode: 2'd2, tick: 1'b0});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick || dut.step_q !== 3'd3) begin
        n_mis++;
        $display("FAIL hold j=%0d got led=%b tick=%b step=%0d want led=%b tick=%b step=3",
                 j, led, tick, dut.step_q, e.led, e.tick);
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      sb.push_back('{led: (j <= 5), mode: 2'd2, tick: (j == 4)});
      clock();
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick) begin
        n_mis++;
        $display("FAIL resume j=%0d got led=%b tick=%b want led=%b tick=%b",
                 j, led, tick, e.led, e.tick);
      end
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    exp_t e;
    do_reset();
    press();
    for (int k = 0; k < 32; k++) begin
      clock();
      sb.push_back('{led: (((since_rst - 1) % 16) < 8), mode: 2'd1, tick: 1'b0});
      e = sb.pop_front();
      n_cmp++;
      if (led !== e.led || mode !== e.mode) begin
        n_mis++;
        $display("FAIL pwm8 k=%0d got led=%b mode=%0d want led=%b mode=%0d",
                 k, led, mode, e.led, e.mode);
      end
      n_cmp++;
      if (led0 !== 1'b0 || mode0 !== 2'd1) begin
        n_mis++;
        $display("FAIL pwm0 k=%0d got led=%b mode=%0d want led=0 mode=1", k, led0, mode0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_blink();
    test_heartbeat();
    test_enable_hold();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
